// File: rtl/hex_display_mux_n.sv
// -----------------------------------------------------------------------------
// hex_display_mux_n
//
// Time-multiplexed driver for a row of common-anode 7-segment displays.
// A packed hex word is decoded one digit at a time while the anodes are
// scanned at a programmable rate. Each slot starts with one dead cycle so the
// previous digit's segments never ghost onto the next anode. Brightness is a
// free-running PWM compare. Leading zeros can be blanked, and new values are
// loaded through a staging register that commits only at a frame boundary,
// so a digit never changes in the middle of its slot.
//
// Parameters
//   DIGITS          number of digits scanned (>= 2)
//   PRESCALE        clock cycles per digit slot (>= 4)
//   DUTY_BITS       width of the brightness control
//   SEG_ACTIVE_LOW  1: seg outputs are active-low
//   AN_ACTIVE_LOW   1: anode outputs are active-low
//
// Ports
//   clk         single clock
//   reset       asynchronous, active-low reset
//   hex_in      packed digits, digit i = hex_in[4i+3:4i], digit 0 rightmost
//   dp_in       decimal point per digit, 1 = lit
//   digit_en    live per-digit enable; 0 keeps that anode dark
//   blank_lz    live leading-zero blanking enable
//   brightness  PWM on-time; 0 = dark, all-ones = always on
//   load        request to capture hex_in / dp_in into staging
//   busy        a captured value is waiting for the next frame boundary
//   frame_tick  one-cycle pulse one cycle after each frame boundary
//   an          anode drives
//   seg         seg[6:0] = gfedcba, seg[7] = dp
// -----------------------------------------------------------------------------
module hex_display_mux_n #(
   parameter int DIGITS         = 8,
   parameter int PRESCALE       = 50000,
   parameter int DUTY_BITS      = 4,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [4*DIGITS-1:0]  hex_in,
   input  logic [DIGITS-1:0]    dp_in,
   input  logic [DIGITS-1:0]    digit_en,
   input  logic                 blank_lz,
   input  logic [DUTY_BITS-1:0] brightness,
   input  logic                 load,
   output logic                 busy,
   output logic                 frame_tick,
   output logic [DIGITS-1:0]    an,
   output logic [7:0]           seg
);

   localparam int PRE_W = $clog2(PRESCALE);
   localparam int IDX_W = $clog2(DIGITS);

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   // XOR masks that turn active-high internal values into pin polarity.
   // They double as the "all inactive" reset value of the pins.
   localparam logic [DIGITS-1:0] AN_INV  = {DIGITS{AN_ACTIVE_LOW != 0}};
   localparam logic [7:0]        SEG_INV = {8{SEG_ACTIVE_LOW != 0}};

   typedef enum logic {
      LOAD_IDLE,
      LOAD_PENDING
   } load_state_t;

   // ---------------------------------------------------------------------------
   // Scan timing
   // ---------------------------------------------------------------------------
   logic [PRE_W-1:0]     pre_cnt;
   logic [IDX_W-1:0]     idx;
   logic [DUTY_BITS-1:0] duty_cnt;
   logic                 slot_end;
   logic                 frame_boundary;

   assign slot_end       = (pre_cnt == PRE_LAST);
   assign frame_boundary = slot_end && (idx == IDX_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_cnt  <= '0;
         idx      <= '0;
         duty_cnt <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values of the others.
         duty_cnt <= duty_cnt + 1'b1;
         if (slot_end) begin
            pre_cnt <= '0;
            idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            pre_cnt <= pre_cnt + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Load handshake: IDLE accepts a capture, PENDING waits for the boundary.
   // A load arriving while PENDING is simply not seen.
   // ---------------------------------------------------------------------------
   load_state_t load_state;
   load_state_t load_state_next;
   logic        capture;
   logic        commit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         load_state <= LOAD_IDLE;
      end else begin
         load_state <= load_state_next;
      end
   end

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      load_state_next = load_state;
      capture         = 1'b0;
      commit          = 1'b0;
      unique case (load_state)
         LOAD_IDLE: begin
            // A load on the boundary cycle itself lands here: it is captured
            // now and committed at the following boundary.
            if (load) begin
               capture         = 1'b1;
               load_state_next = LOAD_PENDING;
            end
         end
         LOAD_PENDING: begin
            if (frame_boundary) begin
               commit          = 1'b1;
               load_state_next = LOAD_IDLE;
            end
         end
         default: load_state_next = LOAD_IDLE;
      endcase
   end

   assign busy = (load_state == LOAD_PENDING);

   // ---------------------------------------------------------------------------
   // Staging and display registers
   // ---------------------------------------------------------------------------
   logic [4*DIGITS-1:0] staging_hex;
   logic [DIGITS-1:0]   staging_dp;
   logic [4*DIGITS-1:0] display_hex;
   logic [DIGITS-1:0]   display_dp;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: these data registers are reset on purpose: the display must
         // come up showing zero and a pending value must not survive reset.
         // A plain datapath register would normally be left without reset.
         staging_hex <= '0;
         staging_dp  <= '0;
         display_hex <= '0;
         display_dp  <= '0;
      end else begin
         if (capture) begin
            staging_hex <= hex_in;
            staging_dp  <= dp_in;
         end
         if (commit) begin
            display_hex <= staging_hex;
            display_dp  <= staging_dp;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Leading-zero detection: lz_mask[i] is set when digit i and every digit
   // above it are zero in the display register.
   // ---------------------------------------------------------------------------
   logic [DIGITS-1:0] lz_mask;

   always_comb begin
      logic run;
      run     = 1'b1;
      lz_mask = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         run        = run && (display_hex[4*i +: 4] == 4'h0);
         lz_mask[i] = run;
      end
   end

   // ---------------------------------------------------------------------------
   // Current-slot decode
   // ---------------------------------------------------------------------------
   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0:    s = 7'h3F;
         4'h1:    s = 7'h06;
         4'h2:    s = 7'h5B;
         4'h3:    s = 7'h4F;
         4'h4:    s = 7'h66;
         4'h5:    s = 7'h6D;
         4'h6:    s = 7'h7D;
         4'h7:    s = 7'h07;
         4'h8:    s = 7'h7F;
         4'h9:    s = 7'h6F;
         4'hA:    s = 7'h77;
         4'hB:    s = 7'h7C;
         4'hC:    s = 7'h39;
         4'hD:    s = 7'h5E;
         4'hE:    s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   logic [3:0]        cur_nibble;
   logic              cur_blank;
   logic              duty_ok;
   logic              anode_on;
   logic [DIGITS-1:0] an_raw;
   logic [7:0]        seg_raw;

   assign cur_nibble = display_hex[4*idx +: 4];

   // Digit 0 always shows something, even a lone zero.
   assign cur_blank  = blank_lz && (idx != '0) && lz_mask[idx];

   // All-ones brightness means 100 %; a plain compare would lose one cycle
   // in every PWM period.
   assign duty_ok    = (duty_cnt < brightness) || (&brightness);

   // Cycle 0 of every slot is dead time against ghosting.
   assign anode_on   = (pre_cnt != '0) && digit_en[idx] && duty_ok;

   always_comb begin
      an_raw      = '0;
      an_raw[idx] = anode_on;
   end

   // Blanking only clears the glyph; the decimal point is kept.
   assign seg_raw = {display_dp[idx], cur_blank ? 7'h00 : hex_to_seg(cur_nibble)};

   // ---------------------------------------------------------------------------
   // Registered pin drives; polarity is applied at the very end.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         an         <= AN_INV;
         seg        <= SEG_INV;
         frame_tick <= 1'b0;
      end else begin
         an         <= an_raw ^ AN_INV;
         seg        <= seg_raw ^ SEG_INV;
         frame_tick <= frame_boundary;
      end
   end

endmodule

// File: tb/tb_hex_display_mux_n.sv
// -----------------------------------------------------------------------------
// tb_hex_display_mux_n
//
// Bench for hex_display_mux_n with DIGITS=8, PRESCALE=4, DUTY_BITS=4 and
// active-low anodes and segments. A cycle model predicts an/seg/frame_tick/
// busy for every clock; the prediction is queued when the inputs are driven
// and compared after the edge that produces it. Directed checks on top cover
// reset, specific glyphs, blanking, PWM on-time counts and the load handshake.
// -----------------------------------------------------------------------------
module tb_hex_display_mux_n;

   localparam int D = 8;
   localparam int P = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] hex_in = '0;
   logic [7:0]  dp_in = '0;
   logic [7:0]  digit_en = '0;
   logic        blank_lz = 1'b0;
   logic [3:0]  brightness = '0;
   logic        load = 1'b0;
   logic        busy;
   logic        frame_tick;
   logic [7:0]  an;
   logic [7:0]  seg;

   always #5 clk = ~clk;

   hex_display_mux_n #(
      .DIGITS        (D),
      .PRESCALE      (P),
      .DUTY_BITS     (4),
      .SEG_ACTIVE_LOW(1),
      .AN_ACTIVE_LOW (1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .hex_in    (hex_in),
      .dp_in     (dp_in),
      .digit_en  (digit_en),
      .blank_lz  (blank_lz),
      .brightness(brightness),
      .load      (load),
      .busy      (busy),
      .frame_tick(frame_tick),
      .an        (an),
      .seg       (seg)
   );

   typedef struct packed {
      logic [7:0] an;
      logic [7:0] seg;
      logic       tick;
      logic       busy;
   } obs_t;

   obs_t sb[$];

   int n_vec = 0;
   int n_err = 0;

   // Reference state: counters as they stand between clock edges.
   int          m_pre, m_idx, m_duty;
   logic [31:0] m_disp, m_stg;
   logic [7:0]  m_dpd, m_stgdp;
   logic        m_busy;

   // Observation helpers filled from the DUT pins.
   logic [7:0] seen_seg [D];
   int         on_cnt;
   logic       last_tick;
   int         steps;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] ref_glyph(input logic [3:0] h);
      case (h)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
      endcase
   endfunction

   task automatic model_reset();
      m_pre = 0; m_idx = 0; m_duty = 0;
      m_disp = '0; m_stg = '0; m_dpd = '0; m_stgdp = '0;
      m_busy = 1'b0;
      sb.delete();
   endtask

   task automatic clear_seen();
      for (int k = 0; k < D; k++) seen_seg[k] = 8'h00;
      on_cnt = 0;
   endtask

   // One clock: predict, push, clock, pop, compare.
   task automatic step();
      obs_t e;
      logic blank;
      e.an = 8'hFF;
      if (m_pre >= 1 && digit_en[m_idx] && (m_duty < int'(brightness) || brightness == 4'hF))
         e.an[m_idx] = 1'b0;
      blank  = blank_lz && (m_idx > 0) && ((m_disp >> (4 * m_idx)) == 32'd0);
      e.seg  = ~{m_dpd[m_idx], blank ? 7'h00 : ref_glyph(m_disp[4*m_idx +: 4])};
      e.tick = (m_pre == P - 1) && (m_idx == D - 1);
      if (e.tick && m_busy) begin
         m_disp = m_stg; m_dpd = m_stgdp; m_busy = 1'b0;
      end else if (load && !m_busy) begin
         m_stg = hex_in; m_stgdp = dp_in; m_busy = 1'b1;
      end
      if (m_pre == P - 1) begin
         m_pre = 0;
         m_idx = (m_idx + 1) % D;
      end else begin
         m_pre++;
      end
      m_duty = (m_duty + 1) % 16;
      e.busy = m_busy;
      sb.push_back(e);

      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("an",   an,         e.an);
      check("seg",  seg,        e.seg);
      check("tick", frame_tick, e.tick);
      check("busy", busy,       e.busy);
      for (int k = 0; k < D; k++)
         if (an[k] === 1'b0) seen_seg[k] = seg;
      if (an !== 8'hFF) on_cnt++;
      last_tick = frame_tick;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   // Steps until frame_tick is seen or the limit runs out.
   task automatic wait_tick(input int limit, output int n);
      n = 0;
      last_tick = 1'b0;
      while (!last_tick && n < limit) begin
         step();
         n++;
      end
      check("tick_within_limit", last_tick, 1'b1);
   endtask

   task automatic load_and_commit(input logic [31:0] h, input logic [7:0] dp);
      hex_in = h; dp_in = dp; load = 1'b1;
      step();
      load = 1'b0;
      hex_in = $urandom;
      dp_in  = 8'($urandom);
      check("busy_after_load", busy, 1'b1);
      wait_tick(40, steps);
      check("busy_clear_at_tick", busy, 1'b0);
   endtask

   initial begin
      // ---------------- reset with random inputs ----------------
      for (int r = 0; r < 2; r++) begin
         hex_in = $urandom; dp_in = 8'($urandom); digit_en = 8'($urandom);
         blank_lz = 1'($urandom); brightness = 4'($urandom); load = 1'b1;
         repeat (2) @(posedge clk);
         #1;
         check("rst_an",   an,         8'hFF);
         check("rst_seg",  seg,        8'hFF);
         check("rst_busy", busy,       1'b0);
         check("rst_tick", frame_tick, 1'b0);
      end

      hex_in = '0; dp_in = '0; digit_en = 8'hFF; blank_lz = 1'b0;
      brightness = 4'hF; load = 1'b0;
      model_reset();
      reset = 1'b1;

      // ---------------- first anode and first frame tick ----------------
      step();
      check("dead_cycle_after_release", an, 8'hFF);
      step();
      check("first_anode_cycle2", an, 8'hFE);
      wait_tick(40, steps);
      check("first_tick_step", steps + 2, 32);

      // ---------------- load 89ABCDEF ----------------
      load_and_commit(32'h89AB_CDEF, 8'h00);
      clear_seen();
      run(32);
      check("digit0_F", seen_seg[0], 8'h8E);
      check("digit3_C", seen_seg[3], 8'hC6);
      check("digit7_8", seen_seg[7], 8'h80);
      check("on_cycles_per_frame", on_cnt, 24);

      // ---------------- leading-zero blanking ----------------
      load_and_commit(32'h0000_00A5, 8'h04);
      blank_lz = 1'b1;
      clear_seen();
      run(32);
      check("lz_digit7_dark", seen_seg[7], 8'hFF);
      check("lz_digit3_dark", seen_seg[3], 8'hFF);
      check("lz_digit2_dp",   seen_seg[2], 8'h7F);
      check("lz_digit1_A",    seen_seg[1], 8'h88);
      check("lz_digit0_5",    seen_seg[0], 8'h92);
      blank_lz = 1'b0;
      clear_seen();
      run(32);
      check("nolz_digit3_0",  seen_seg[3], 8'hC0);

      // A zero below a non-zero digit is never blanked.
      load_and_commit(32'h0000_0A05, 8'h00);
      blank_lz = 1'b1;
      clear_seen();
      run(32);
      check("lz_inner_zero",  seen_seg[1], 8'hC0);
      check("lz_digit2_A",    seen_seg[2], 8'h88);
      check("lz_digit3_dark", seen_seg[3], 8'hFF);
      blank_lz = 1'b0;

      // ---------------- brightness ----------------
      brightness = 4'h0;
      clear_seen();
      run(64);
      check("bright0_on", on_cnt, 0);
      brightness = 4'h8;
      clear_seen();
      run(64);
      check("bright8_on", on_cnt, 24);
      brightness = 4'hF;
      clear_seen();
      run(64);
      check("brightF_on", on_cnt, 48);

      // ---------------- second load while busy is dropped ----------------
      hex_in = 32'h1111_1111; dp_in = 8'h00; load = 1'b1;
      step();
      hex_in = 32'h2222_2222;
      step();
      load = 1'b0;
      check("busy_held", busy, 1'b1);
      wait_tick(40, steps);
      check("busy_clear_at_tick2", busy, 1'b0);
      clear_seen();
      run(32);
      check("kept_first_d0", seen_seg[0], 8'hF9);
      check("kept_first_d5", seen_seg[5], 8'hF9);

      // ---------------- load on the frame-boundary cycle ----------------
      for (int i = 0; i < 40 && !(m_pre == P - 1 && m_idx == D - 1); i++) step();
      hex_in = 32'h3333_3333; load = 1'b1;
      step();
      load = 1'b0;
      check("bnd_tick",         frame_tick, 1'b1);
      check("bnd_busy_set",     busy,       1'b1);
      clear_seen();
      run(32);
      check("bnd_old_value",    seen_seg[0], 8'hF9);
      check("bnd_commit_tick",  frame_tick,  1'b1);
      check("bnd_busy_cleared", busy,        1'b0);
      clear_seen();
      run(32);
      check("bnd_new_value",    seen_seg[0], 8'hB0);

      // ---------------- reset mid-slot of digit 5 with pending load ----------------
      for (int i = 0; i < 40 && !(m_idx == 5 && m_pre == 2); i++) step();
      hex_in = 32'h4444_4444; load = 1'b1;
      step();
      load = 1'b0;
      check("pending_before_reset", busy, 1'b1);
      reset = 1'b0;
      #1;
      check("midrst_an",   an,         8'hFF);
      check("midrst_seg",  seg,        8'hFF);
      check("midrst_busy", busy,       1'b0);
      check("midrst_tick", frame_tick, 1'b0);
      @(posedge clk);
      #1;
      model_reset();
      reset = 1'b1;
      clear_seen();
      wait_tick(40, steps);
      check("tick_after_reset", steps, 32);
      check("post_rst_digit0", seen_seg[0], 8'hC0);
      check("post_rst_digit5", seen_seg[5], 8'hC0);
      check("post_rst_busy",   busy,        1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
